rosc_sched_ctrl: RTL and testbench
==================================

# rosc_sched_ctrl

Measurement scheduler for the bank of NOR-chain ring oscillators used as aging sensors. It walks a channel mask one ring at a time: enable the ring, wait a settle period, count prescaled oscillator edges over a programmed window, then report the count. The block sits between the register interface and the ROSC bank. It is the only logic that drives ring enables and the output-mux select.

## Interface
- NUM_ROSC, 4: number of ring channels.
- SEL_W, $clog2(NUM_ROSC): mux select width.
- CNT_W, 16: result counter width.
- WIN_W, 16: window-length width.
- SETTLE_CYC, 8: CLK cycles between enable and counting, minimum 1.
- CLK  in  1  system clock. One clock domain only.
- RESETN  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle start pulse; ignored while BUSY.
- CH_MASK  in  NUM_ROSC  channels to measure; captured on START.
- WIN_LEN  in  WIN_W  count window in CLK cycles; captured on START.
- ROSC_DIV  in  1  prescaled, muxed output of the selected ring; asynchronous to CLK, frequency at most CLK/4.
- ROSC_EN  out  NUM_ROSC  one-hot ring enable, or all-zero.
- ROSC_SEL  out  SEL_W  output-mux select.
- BUSY  out  1  high from the cycle after an accepted START until DONE.
- RES_VALID  out  1  result available.
- RES_READY  in  1  consumer accepts the result.
- RES_CH  out  SEL_W  channel of the current result.
- RES_COUNT  out  CNT_W  edge count, saturating.
- DONE  out  1  one-cycle pulse when the sweep finishes.

## Operation
- FSM states: IDLE, SETTLE, COUNT, DRAIN, REPORT, NEXT.
- IDLE -> NEXT on START with BUSY low. Latch CH_MASK and WIN_LEN; set scan pointer to 0.
- NEXT:
  - Selects the lowest set mask bit at or above the pointer.
  - If one exists: ROSC_SEL = that channel, clear its latched mask bit, go to SETTLE.
  - If none remain: pulse DONE, go to IDLE.
- SETTLE:
  - ROSC_EN[ch] = 1 for SETTLE_CYC cycles. Counter cleared.
  - Then go to COUNT, or to DRAIN if WIN_LEN = 0.
- COUNT: runs WIN_LEN cycles; the ring stays enabled.
- DRAIN: 3 cycles; ring still enabled, covering the sync latency.
- REPORT:
  - ROSC_EN all-zero; RES_VALID = 1.
  - RES_CH and RES_COUNT are held stable until RES_VALID && RES_READY.
  - After the handshake, go to NEXT.
- Edge counting:
  - ROSC_DIV passes through a 2-flop synchronizer, then a rising-edge detector.
  - The count enable is the COUNT flag delayed 3 cycles, so exactly WIN_LEN synchronized samples are counted.
  - The counter increments on each detected edge and saturates at 2^CNT_W-1.
- Boundary rules:
  - CH_MASK = 0: DONE pulses the cycle after the NEXT evaluation; no RES_VALID.
  - WIN_LEN = 0: the result reports a count of 0.
  - START during BUSY: ignored; latched values are unchanged.
  - RESETN low mid-sweep: all outputs go to reset values immediately, no DONE pulse, latched mask cleared.
- Reset values: state IDLE, ROSC_EN = 0, ROSC_SEL = 0, BUSY = 0, RES_VALID = 0, RES_CH = 0, RES_COUNT = 0, DONE = 0.
- ROSC_SEL changes only in NEXT, while ROSC_EN is all-zero (glitch-free mux switching).

## Timing
- START sampled at edge t; NEXT occupies t+1; ROSC_EN goes high at t+2.
- COUNT starts at t+2+SETTLE_CYC.
- RES_VALID rises at t+2+SETTLE_CYC+WIN_LEN+3, i.e. SETTLE_CYC+WIN_LEN+5 cycles after START.
- The handshake is sampled at an edge. The next channel's ROSC_EN rises 2 cycles later (one NEXT cycle in between).
- With RES_READY tied high, RES_VALID lasts exactly 1 cycle.
- DONE pulses 1 cycle after the last handshake; BUSY falls in the same cycle as DONE.

## Structure
- Package rosc_ctrl_pkg holds:
  - the state enum;
  - the DRAIN_CYC = 3 and SYNC_STAGES = 2 constants;
  - a default CNT_W.
- Sub-module rosc_edge_counter contains the synchronizer, the edge detector and the saturating counter, with ports clear, count_en, async_in and count.
- The FSM, scan pointer, latches and result holding registers stay in rosc_sched_ctrl.

## Test plan
- Single channel: CH_MASK=0001, WIN_LEN=100, ROSC_DIV period 8 cycles, RES_READY=1 -> RES_CH=0, RES_COUNT within 12..13, RES_VALID at START+113, DONE at START+114.
- Mask skip: CH_MASK=1010 -> results for channels 1 then 3 only; ROSC_EN equals 0010 then 1000 and is never two-hot; ROSC_SEL never changes while ROSC_EN is nonzero.
- Backpressure: RES_READY held low 20 cycles -> RES_VALID, RES_CH and RES_COUNT stay stable, ROSC_EN=0, next channel not enabled until 2 cycles after the handshake.
- Saturation: CNT_W=4, WIN_LEN=200, ROSC_DIV period 4 -> RES_COUNT=15.
- Edge cases:
  - CH_MASK=0 -> DONE 2 cycles after START, no RES_VALID.
  - WIN_LEN=0 -> RES_COUNT=0.
  - A second START while BUSY -> no effect.
- Reset mid-COUNT: RESETN low for 1 cycle -> ROSC_EN=0 and BUSY=0 immediately, no DONE; a fresh START afterwards runs normally.

Source files
------------

// File: rtl/rosc_ctrl_pkg.sv
// Shared types and constants for the ring-oscillator
// measurement scheduler.
package rosc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_COUNT,
        S_DRAIN,
        S_REPORT,
        S_NEXT
    } state_t;

    localparam int DRAIN_CYC   = 3;
    localparam int SYNC_STAGES = 2;
    localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/rosc_edge_counter.sv
// Synchronizes the muxed ring output, detects rising
// edges and counts them with saturation.
module rosc_edge_counter
    import rosc_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             count_en,
    input  logic             async_in,
    output logic [CNT_W-1:0] count
);

    logic [SYNC_STAGES:0] sync_q;
    logic                 rise;

    // Synchronizer chain plus one stage for edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-1:0], async_in};
        end
    end

    assign rise = sync_q[SYNC_STAGES-1]
                & ~sync_q[SYNC_STAGES];

    // Saturating edge counter, clear has priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && rise && count != '1) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rosc_sched_ctrl.sv
// Sweeps the channel mask one ring at a time:
// enable, settle, count a window, report.
module rosc_sched_ctrl
    import rosc_ctrl_pkg::*;
#(
    parameter int NUM_ROSC   = 4,
    parameter int SEL_W      = $clog2(NUM_ROSC),
    parameter int CNT_W      = DEF_CNT_W,
    parameter int WIN_W      = 16,
    parameter int SETTLE_CYC = 8
) (
    input  logic                CLK,
    input  logic                RESETN,
    input  logic                START,
    input  logic [NUM_ROSC-1:0] CH_MASK,
    input  logic [WIN_W-1:0]    WIN_LEN,
    input  logic                ROSC_DIV,
    output logic [NUM_ROSC-1:0] ROSC_EN,
    output logic [SEL_W-1:0]    ROSC_SEL,
    output logic                BUSY,
    output logic                RES_VALID,
    input  logic                RES_READY,
    output logic [SEL_W-1:0]    RES_CH,
    output logic [CNT_W-1:0]    RES_COUNT,
    output logic                DONE
);

    localparam logic [WIN_W-1:0] SETTLE_LAST =
        WIN_W'(SETTLE_CYC - 1);
    localparam logic [WIN_W-1:0] DRAIN_LAST =
        WIN_W'(DRAIN_CYC - 1);

    state_t                state_q, state_d;
    logic [NUM_ROSC-1:0]   mask_q;
    logic [WIN_W-1:0]      win_q;
    logic [WIN_W-1:0]      timer_q;
    logic [SEL_W-1:0]      ptr_q;
    logic [SEL_W-1:0]      sel_q;
    logic [SEL_W-1:0]      ch_q;
    logic [DRAIN_CYC-1:0]  cflag_q;
    logic                  done_q, done_d;
    logic                  take;
    logic                  found;
    logic [SEL_W-1:0]      found_ch;
    logic                  cnt_clear;
    logic                  cnt_en;

    // Lowest pending channel at or above the pointer
    always_comb begin
        found    = 1'b0;
        found_ch = '0;
        for (int i = NUM_ROSC - 1; i >= 0; i--) begin
            if (mask_q[i] && i >= int'(ptr_q)) begin
                found    = 1'b1;
                found_ch = SEL_W'(i);
            end
        end
    end

    // Next-state logic; a sweep with nothing left ends
    // straight from the last handshake
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        take    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (START) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (found) begin
                    take    = 1'b1;
                    state_d = S_SETTLE;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (timer_q == SETTLE_LAST)
                    state_d = (win_q == '0) ? S_DRAIN
                                            : S_COUNT;
            end
            S_COUNT: begin
                if (timer_q == win_q - WIN_W'(1))
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (timer_q == DRAIN_LAST)
                    state_d = S_REPORT;
            end
            S_REPORT: begin
                if (RES_READY) begin
                    if (found) begin
                        state_d = S_NEXT;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register and per-state cycle timer
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            timer_q <= (state_d != state_q) ? '0
                     : timer_q + WIN_W'(1);
        end
    end

    // Sweep latches, channel select and result channel
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            mask_q <= '0;
            win_q  <= '0;
            ptr_q  <= '0;
            sel_q  <= '0;
            ch_q   <= '0;
        end else begin
            if (state_q == S_IDLE && START) begin
                mask_q <= CH_MASK;
                win_q  <= WIN_LEN;
                ptr_q  <= '0;
            end else if (take) begin
                mask_q[found_ch] <= 1'b0;
                ptr_q            <= found_ch;
                sel_q            <= found_ch;
            end
            if (state_q == S_DRAIN && state_d == S_REPORT)
                ch_q <= sel_q;
        end
    end

    // Delay the COUNT flag to match synchronizer latency
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            cflag_q <= '0;
        end else begin
            cflag_q <= {cflag_q[DRAIN_CYC-2:0],
                        state_q == S_COUNT};
        end
    end

    assign cnt_en    = cflag_q[DRAIN_CYC-1];
    assign cnt_clear = (state_q == S_SETTLE);

    rosc_edge_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (CLK),
        .rst_n    (RESETN),
        .clear    (cnt_clear),
        .count_en (cnt_en),
        .async_in (ROSC_DIV),
        .count    (RES_COUNT)
    );

    // One-hot ring enable while the ring is in use
    always_comb begin
        ROSC_EN = '0;
        if (state_q inside {S_SETTLE, S_COUNT, S_DRAIN})
            ROSC_EN[sel_q] = 1'b1;
    end

    // Mux select moves only during NEXT, rings all off
    assign ROSC_SEL  = (state_q == S_NEXT && found)
                     ? found_ch : sel_q;
    assign BUSY      = (state_q != S_IDLE);
    assign RES_VALID = (state_q == S_REPORT);
    assign RES_CH    = ch_q;
    assign DONE      = done_q;

endmodule

// File: tb/tb_rosc_sched_ctrl.sv
// Directed bench for the ring-oscillator scheduler,
// including a narrow-counter instance for saturation.
module tb_rosc_sched_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        rosc_div = 1'b0;
    logic        res_ready = 1'b1;
    logic [3:0]  ch_mask = '0;
    logic [15:0] win_len = '0;

    logic [3:0]  rosc_en, s_en;
    logic [1:0]  rosc_sel, res_ch, s_sel, s_ch;
    logic        busy, res_valid, done;
    logic        s_busy, s_valid, s_done;
    logic [15:0] res_count;
    logic [3:0]  s_count;

    int passed = 0;
    int total = 0;
    int div_half = 40;

    always #5 clk = ~clk;

    initial begin
        #3;
        forever begin
            #(div_half);
            rosc_div = ~rosc_div;
        end
    end

    rosc_sched_ctrl dut (
        .CLK(clk), .RESETN(resetn), .START(start),
        .CH_MASK(ch_mask), .WIN_LEN(win_len),
        .ROSC_DIV(rosc_div), .ROSC_EN(rosc_en),
        .ROSC_SEL(rosc_sel), .BUSY(busy),
        .RES_VALID(res_valid), .RES_READY(res_ready),
        .RES_CH(res_ch), .RES_COUNT(res_count),
        .DONE(done)
    );

    rosc_sched_ctrl #(.CNT_W(4)) dut_sat (
        .CLK(clk), .RESETN(resetn), .START(start),
        .CH_MASK(ch_mask), .WIN_LEN(win_len),
        .ROSC_DIV(rosc_div), .ROSC_EN(s_en),
        .ROSC_SEL(s_sel), .BUSY(s_busy),
        .RES_VALID(s_valid), .RES_READY(res_ready),
        .RES_CH(s_ch), .RES_COUNT(s_count),
        .DONE(s_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [3:0] m,
                               input logic [15:0] w);
        ch_mask = m;
        win_len = w;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        total++;
        if (rosc_en !== 4'b0)
            $display("FAIL rst_en got %b want 0000", rosc_en);
        else passed++;
        total++;
        if ({busy, res_valid, done} !== 3'b000)
            $display("FAIL rst_flags got %b want 000",
                     {busy, res_valid, done});
        else passed++;
        total++;
        if ({rosc_sel, res_ch} !== 4'b0 || res_count !== 16'd0)
            $display("FAIL rst_res got %0d/%0d/%0d want 0/0/0",
                     rosc_sel, res_ch, res_count);
        else passed++;
        resetn = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0)
            $display("FAIL idle_busy got %b want 0", busy);
        else passed++;
    endtask

    task automatic test_single();
        int n;
        res_ready = 1'b1;
        pulse_start(4'b0001, 16'd100);
        n = 1;
        total++;
        if (busy !== 1'b1 || rosc_en !== 4'b0)
            $display("FAIL single_next got %b/%b want 1/0000",
                     busy, rosc_en);
        else passed++;
        tick();
        n = 2;
        total++;
        if (rosc_en !== 4'b0001)
            $display("FAIL single_en got %b want 0001", rosc_en);
        else passed++;
        while (!res_valid && n < 300) begin
            tick();
            n++;
        end
        total++;
        if (n != 113)
            $display("FAIL single_lat got %0d want 113", n);
        else passed++;
        total++;
        if (res_ch !== 2'd0)
            $display("FAIL single_ch got %0d want 0", res_ch);
        else passed++;
        total++;
        if (res_count < 16'd12 || res_count > 16'd13)
            $display("FAIL single_cnt got %0d want 12..13",
                     res_count);
        else passed++;
        tick();
        total++;
        if ({done, busy, res_valid} !== 3'b100)
            $display("FAIL single_done got %b want 100",
                     {done, busy, res_valid});
        else passed++;
        tick();
        total++;
        if (done !== 1'b0)
            $display("FAIL single_pulse got %b want 0", done);
        else passed++;
    endtask

    task automatic test_mask_skip();
        int n, nres, nen, bad_hot, bad_sel;
        logic [1:0] chs [2];
        logic [3:0] ens [4];
        logic [3:0] pen;
        logic [1:0] psel;
        nres = 0; nen = 0; bad_hot = 0; bad_sel = 0;
        chs[0] = 2'd0; chs[1] = 2'd0;
        for (int i = 0; i < 4; i++) ens[i] = 4'b0;
        res_ready = 1'b1;
        pulse_start(4'b1010, 16'd20);
        n = 1;
        pen = rosc_en;
        psel = rosc_sel;
        while (!done && n < 400) begin
            if ((rosc_en & (rosc_en - 4'd1)) != 4'b0)
                bad_hot++;
            if (rosc_sel !== psel &&
                (rosc_en != 4'b0 || pen != 4'b0))
                bad_sel++;
            if (rosc_en != 4'b0 && nen < 4 &&
                (nen == 0 || ens[nen-1] != rosc_en)) begin
                ens[nen] = rosc_en;
                nen++;
            end
            if (res_valid && res_ready) begin
                if (nres < 2) chs[nres] = res_ch;
                nres++;
            end
            pen = rosc_en;
            psel = rosc_sel;
            tick();
            n++;
        end
        total++;
        if (n != 67)
            $display("FAIL skip_done got %0d want 67", n);
        else passed++;
        total++;
        if (nres != 2 || chs[0] !== 2'd1 || chs[1] !== 2'd3)
            $display("FAIL skip_ch got %0d:%0d,%0d want 2:1,3",
                     nres, chs[0], chs[1]);
        else passed++;
        total++;
        if (nen != 2 || ens[0] !== 4'b0010 ||
            ens[1] !== 4'b1000)
            $display("FAIL skip_en got %0d:%b,%b want 2:0010,1000",
                     nen, ens[0], ens[1]);
        else passed++;
        total++;
        if (bad_hot != 0 || bad_sel != 0)
            $display("FAIL skip_glitch got %0d/%0d want 0/0",
                     bad_hot, bad_sel);
        else passed++;
    endtask

    task automatic test_backpressure();
        int n, bad;
        logic [1:0] ch;
        logic [15:0] cnt;
        bad = 0;
        res_ready = 1'b0;
        pulse_start(4'b0011, 16'd10);
        n = 1;
        while (!res_valid && n < 300) begin
            tick();
            n++;
        end
        total++;
        if (n != 23)
            $display("FAIL bp_lat got %0d want 23", n);
        else passed++;
        ch = res_ch;
        cnt = res_count;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (res_valid !== 1'b1 || res_ch !== ch ||
                res_count !== cnt || rosc_en !== 4'b0)
                bad++;
        end
        total++;
        if (bad != 0 || ch !== 2'd0)
            $display("FAIL bp_hold got %0d/%0d want 0/0",
                     bad, ch);
        else passed++;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        total++;
        if (rosc_en !== 4'b0 || res_valid !== 1'b0)
            $display("FAIL bp_gap got %b/%b want 0000/0",
                     rosc_en, res_valid);
        else passed++;
        tick();
        total++;
        if (rosc_en !== 4'b0010)
            $display("FAIL bp_next got %b want 0010", rosc_en);
        else passed++;
        res_ready = 1'b1;
        n = 0;
        while (!done && n < 300) begin
            tick();
            n++;
        end
        total++;
        if (done !== 1'b1)
            $display("FAIL bp_done got %b want 1", done);
        else passed++;
        tick();
    endtask

    task automatic test_saturation();
        int n;
        div_half = 20;
        res_ready = 1'b1;
        tick();
        pulse_start(4'b0001, 16'd200);
        n = 1;
        while (!res_valid && n < 400) begin
            tick();
            n++;
        end
        total++;
        if (n != 213 || s_valid !== 1'b1)
            $display("FAIL sat_lat got %0d/%b want 213/1",
                     n, s_valid);
        else passed++;
        total++;
        if (s_count !== 4'd15)
            $display("FAIL sat_cnt got %0d want 15", s_count);
        else passed++;
        total++;
        if (res_count !== 16'd50)
            $display("FAIL sat_wide got %0d want 50", res_count);
        else passed++;
        tick();
        tick();
        div_half = 40;
    endtask

    task automatic test_empty_mask();
        pulse_start(4'b0000, 16'd5);
        total++;
        if ({busy, done, res_valid} !== 3'b100)
            $display("FAIL empty_n1 got %b want 100",
                     {busy, done, res_valid});
        else passed++;
        tick();
        total++;
        if ({busy, done, res_valid} !== 3'b010)
            $display("FAIL empty_done got %b want 010",
                     {busy, done, res_valid});
        else passed++;
        tick();
    endtask

    task automatic test_zero_window();
        int n;
        pulse_start(4'b0100, 16'd0);
        n = 1;
        while (!res_valid && n < 200) begin
            tick();
            n++;
        end
        total++;
        if (n != 13 || res_ch !== 2'd2)
            $display("FAIL zw_lat got %0d/%0d want 13/2",
                     n, res_ch);
        else passed++;
        total++;
        if (res_count !== 16'd0)
            $display("FAIL zw_cnt got %0d want 0", res_count);
        else passed++;
        tick();
        total++;
        if (done !== 1'b1)
            $display("FAIL zw_done got %b want 1", done);
        else passed++;
        tick();
    endtask

    task automatic test_start_while_busy();
        int n, nres, vn;
        logic [1:0] ch0;
        nres = 0; vn = 0; ch0 = 2'd3;
        pulse_start(4'b0001, 16'd30);
        n = 1;
        while (n < 5) begin
            tick();
            n++;
        end
        ch_mask = 4'b1111;
        win_len = 16'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n++;
        while (!done && n < 300) begin
            if (res_valid) begin
                if (nres == 0) begin
                    ch0 = res_ch;
                    vn = n;
                end
                nres++;
            end
            tick();
            n++;
        end
        total++;
        if (nres != 1 || ch0 !== 2'd0 || vn != 43)
            $display("FAIL busy_start got %0d/%0d/%0d want 1/0/43",
                     nres, ch0, vn);
        else passed++;
        total++;
        if (n != 44)
            $display("FAIL busy_done got %0d want 44", n);
        else passed++;
        tick();
    endtask

    task automatic test_reset_mid();
        int n, seen;
        seen = 0;
        pulse_start(4'b0011, 16'd100);
        n = 1;
        while (n < 20) begin
            tick();
            n++;
        end
        total++;
        if (rosc_en !== 4'b0001)
            $display("FAIL rm_pre got %b want 0001", rosc_en);
        else passed++;
        resetn = 1'b0;
        #1;
        total++;
        if (rosc_en !== 4'b0 || busy !== 1'b0 ||
            res_valid !== 1'b0)
            $display("FAIL rm_async got %b/%b/%b want 0000/0/0",
                     rosc_en, busy, res_valid);
        else passed++;
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (done || busy) seen++;
            tick();
        end
        total++;
        if (seen != 0)
            $display("FAIL rm_quiet got %0d want 0", seen);
        else passed++;
        pulse_start(4'b0001, 16'd10);
        n = 1;
        while (!res_valid && n < 200) begin
            tick();
            n++;
        end
        total++;
        if (n != 23 || res_ch !== 2'd0)
            $display("FAIL rm_fresh got %0d/%0d want 23/0",
                     n, res_ch);
        else passed++;
        tick();
        total++;
        if (done !== 1'b1)
            $display("FAIL rm_done got %b want 1", done);
        else passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_mask_skip();
        test_backpressure();
        test_saturation();
        test_empty_mask();
        test_zero_window();
        test_start_while_busy();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
